// File: rtl/led_frame_loader_pkg.sv
// Shared types and geometry for the LED frame loader and its bank RAM.
package led_pkg;

    localparam int unsigned LED_ROWS  = 9;
    localparam int unsigned LED_COLS  = 8;
    localparam int unsigned LED_ROW_W = 4;

    typedef logic [LED_COLS-1:0] led_row_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } loader_state_t;

endpackage

// File: rtl/led_frame_loader_if.sv
// Byte-stream valid/ready handshake feeding the LED frame loader.
interface led_frame_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/led_frame_loader_bank_ram.sv
// Double-buffered row storage: writes go to the back bank, the registered
// read port serves the active bank selected by bank_sel.
module led_bank_ram
    import led_pkg::*;
#(
    parameter int unsigned ROWS = LED_ROWS,
    parameter int unsigned COLS = LED_COLS
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 bank_sel,
    input  logic                 wr_en,
    input  logic [LED_ROW_W-1:0] wr_addr,
    input  logic [COLS-1:0]      wr_data,
    input  logic [LED_ROW_W-1:0] rd_addr,
    output logic [COLS-1:0]      rd_data
);

    localparam logic [LED_ROW_W-1:0] LAST_ROW = LED_ROW_W'(ROWS - 1);

    logic [COLS-1:0] bank [2][ROWS];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_en && (wr_addr <= LAST_ROW)) begin
                bank[~bank_sel][wr_addr] <= wr_data;
            end
            rd_data <= (rd_addr <= LAST_ROW) ? bank[bank_sel][rd_addr] : '0;
        end
    end

endmodule

// File: rtl/led_frame_loader.sv
// Frame parser (sync byte + ROWS row bytes) with bank swap on frame_start.
// Optional idle-gap abandon of partial frames: LED_FRAME_LOADER_TIMEOUT_EN.
module led_frame_loader
    import led_pkg::*;
#(
    parameter int unsigned ROWS        = LED_ROWS,
    parameter int unsigned COLS        = LED_COLS,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 270000
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    led_frame_loader_if.slave    in_bus,
    input  logic                 frame_start,
    input  logic [LED_ROW_W-1:0] rd_row,
    output logic [COLS-1:0]      rd_data,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 timeout
);

    localparam logic [LED_ROW_W-1:0] LAST_ROW = LED_ROW_W'(ROWS - 1);

    if (ROWS < 1 || ROWS > (1 << LED_ROW_W) || COLS != 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("led_frame_loader: unsupported ROWS/COLS/TIMEOUT_CYC");
    end

    loader_state_t        state;
    logic [LED_ROW_W-1:0] row_cnt;
    logic                 bank_sel;
    logic                 in_ready_q;
    logic                 accept;
    logic                 wr_en;

    assign in_bus.in_ready = in_ready_q;
    assign accept          = in_bus.in_valid && in_ready_q;
    assign wr_en           = (state == LOAD) && accept;

`ifdef LED_FRAME_LOADER_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);
    logic [GAP_W-1:0] gap_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_cnt    <= '0;
            bank_sel   <= 1'b0;
            in_ready_q <= 1'b1;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef LED_FRAME_LOADER_TIMEOUT_EN
            timeout    <= 1'b0;
            gap_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef LED_FRAME_LOADER_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_bus.in_data == SYNC_BYTE) begin
                            state   <= LOAD;
                            row_cnt <= '0;
`ifdef LED_FRAME_LOADER_TIMEOUT_EN
                            gap_cnt <= '0;
`endif
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Every payload byte is row data, SYNC_BYTE included.
                        if (row_cnt == LAST_ROW) begin
                            state      <= PENDING;
                            in_ready_q <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
`ifdef LED_FRAME_LOADER_TIMEOUT_EN
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_W'(TIMEOUT_CYC - 1)) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
`endif
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        bank_sel   <= ~bank_sel;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    led_bank_ram #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank_ram (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .bank_sel (bank_sel),
        .wr_en    (wr_en),
        .wr_addr  (row_cnt),
        .wr_data  (in_bus.in_data),
        .rd_addr  (rd_row),
        .rd_data  (rd_data)
    );

endmodule
